rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file `rf` between NUM_REQ writeback requesters, e.g. the ALU and the load unit.
- Each requester uses a valid/ready handshake. Arbitration is round-robin, and the winning request is registered onto the rf write port.
- Writes to x0 are suppressed.
- Also provides a read-after-write bypass on the two rf read ports and a saturating counter of contended cycles.

Parameters:
- NUM_REQ, 2: number of writeback requesters; legal range 2..4.
- CNT_W, 16: width of the contention counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; combinational, one-hot or zero.
- req_rd  in  NUM_REQ*5  packed destination register index; requester i occupies bits [5i+4:5i].
- req_data  in  NUM_REQ*32  packed write data; requester i occupies bits [32i+31:32i].
- wb_stall  in  1  when high, no requester is granted this cycle.
- write_e  out  1  registered write enable to rf.
- rd  out  5  registered write address to rf.
- write_d  out  32  registered write data to rf.
- reg_s1, reg_s2  in  5  read addresses currently driven to rf.
- rf_d1, rf_d2  in  32  raw rf read data.
- reg_d1, reg_d2  out  32  bypassed read data to consumers.
- conflict_cnt  out  CNT_W  count of cycles in which two or more requesters were valid and stall was low.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - write_e=0, rd=0, write_d=0, conflict_cnt=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has priority first.
  - req_ready=0 while rst is high.
- Arbitration (combinational, each cycle):
  - If wb_stall=1 or rst=1, all req_ready are 0.
  - Otherwise, grant the first valid requester searching upward from last_grant+1, modulo NUM_REQ.
  - At most one req_ready is high, and a ready is never asserted without its valid.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i] at a posedge.
  - Requesters hold rd and data stable until the transfer.
  - Deasserting valid before the transfer is allowed; the request is withdrawn.
- Write-port register (on each posedge):
  - On a transfer from i: last_grant<=i, rd<=req_rd[i], write_d<=req_data[i].
  - write_e<=1 only if req_rd[i]!=0.
  - A transfer with rd=x0 still completes and still updates last_grant, but produces write_e=0.
  - With no transfer: write_e<=0; rd and write_d hold their previous values.
- Latency: the transfer edge N puts write_e high during cycle N..N+1, and rf commits the write at edge N+1. Throughput is one write per cycle.
- Contention counter:
  - Increments at each posedge where popcount(req_valid)>=2 and wb_stall=0.
  - Saturates at 2^CNT_W-1, with no wrap.
  - Cleared only by rst.
- Read bypass: see Optional Feature.
- Reset mid-operation: any pending registered write is dropped (write_e=0 the following cycle). Requesters must re-present.
- Simultaneous events:
  - wb_stall overrides all valids.
  - rst overrides wb_stall.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - reg_d1 = write_d when write_e=1, rd==reg_s1 and reg_s1!=0; otherwise reg_d1 = rf_d1.
  - reg_d2 is formed the same way using reg_s2 and rf_d2.
  - This bypass is combinational, covering the cycle in which the write is pending at the rf port.
- Not defined: reg_d1=rf_d1 and reg_d2=rf_d2 unconditionally, with no added logic.

Test Plan:
1. After rst, a single transfer from requester 0 with rd=4, data=42 -> req_ready[0]=1 that cycle; next cycle write_e=1, rd=4, write_d=42. One cycle later, reading reg_s1=4 returns 42 and reg_s2=0 returns 0.
2. Requesters 0 and 1 both valid for 4 cycles (r0: rd=2, data=99; r1: rd=3, data=7) -> grants alternate 0,1,0,1; writes alternate x2=99, x3=7; conflict_cnt=4.
3. Requester 1 valid with rd=0, data=0xDEAD -> req_ready[1]=1, write_e stays 0, and x0 still reads 0. The next contended cycle grants requester 0.
4. wb_stall=1 for 3 cycles with both requesters valid -> req_ready=0 and write_e=0 throughout; conflict_cnt unchanged. Stall released -> requester following last_grant is granted first.
5. With RF_WB_BYPASS_EN, in the cycle write_e=1, rd=5, write_d=0x1234 and reg_s1=5 -> reg_d1=0x1234 while rf_d1 still shows the old value. Without the macro -> reg_d1=rf_d1.
6. rst asserted in the cycle after a transfer, and CNT_W=2 with 5 contended cycles before that reset -> write_e=0 after the reset edge; conflict_cnt saturates at 3 before the reset and is 0 after.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single write port of a 32x32 register file between NUM_REQ
// writeback requesters. Arbitration is round-robin over valid/ready
// handshakes. The winning request is registered onto the rf write port.
// Writes to x0 still complete the handshake but never raise write_e.
// A saturating counter tracks contended cycles.
//
// Optional feature (macro RF_WB_BYPASS_EN): a combinational read-after-write
// bypass on the two rf read ports covers the cycle in which a write is
// pending at the rf port. Without the macro, reg_d1/reg_d2 pass rf_d1/rf_d2
// straight through.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready per-requester handshake (ready is one-hot or zero)
//   req_rd, req_data    packed per-requester destination index / data
//   wb_stall            blocks all grants this cycle
//   write_e, rd, write_d registered rf write port
//   reg_s1/2, rf_d1/2   read addresses and raw rf read data
//   reg_d1/2            (optionally bypassed) read data to consumers
//   conflict_cnt        saturating count of contended, unstalled cycles
module rf_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*5-1:0]   req_rd,
  input  logic [NUM_REQ*32-1:0]  req_data,
  input  logic                   wb_stall,
  output logic                   write_e,
  output logic [4:0]             rd,
  output logic [31:0]            write_d,
  input  logic [4:0]             reg_s1,
  input  logic [4:0]             reg_s2,
  input  logic [31:0]            rf_d1,
  input  logic [31:0]            rf_d2,
  output logic [31:0]            reg_d1,
  output logic [31:0]            reg_d2,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             write_e_q, write_e_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      write_d_q, write_d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             grant_vld_s;
  logic [IDX_W-1:0] grant_idx_s;
  logic [4:0]       sel_rd_s;
  logic [31:0]      sel_data_s;
  logic             contended_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = last_grant_q;
    req_ready   = '0;
    if (!rst && !wb_stall) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant_vld_s && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
    if (grant_vld_s) begin
      req_ready = NUM_REQ'(1) << grant_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  assign sel_rd_s    = req_rd[int'(grant_idx_s) * 5 +: 5];
  assign sel_data_s  = req_data[int'(grant_idx_s) * 32 +: 32];
  // Stall suppresses contention counting as well as grants.
  assign contended_s = !wb_stall && ($countones(req_valid) >= 2);

  // Next-state for the write-port register, round-robin pointer and counter.
  always_comb begin
    last_grant_d = last_grant_q;
    write_e_d    = 1'b0;
    rd_d         = rd_q;
    write_d_d    = write_d_q;
    cnt_d        = cnt_q;
    if (grant_vld_s) begin
      // An x0 transfer still completes and moves the pointer, but never writes.
      last_grant_d = grant_idx_s;
      rd_d         = sel_rd_s;
      write_d_d    = sel_data_s;
      write_e_d    = (sel_rd_s != 5'd0);
    end else begin
      write_e_d    = 1'b0;
    end
    if (contended_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register with synchronous reset; reset drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_RST;
      write_e_q    <= 1'b0;
      rd_q         <= 5'd0;
      write_d_q    <= 32'd0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      write_e_q    <= write_e_d;
      rd_q         <= rd_d;
      write_d_q    <= write_d_d;
      cnt_q        <= cnt_d;
    end
  end

  assign write_e      = write_e_q;
  assign rd           = rd_q;
  assign write_d      = write_d_q;
  assign conflict_cnt = cnt_q;

`ifdef RF_WB_BYPASS_EN
  // Forward the pending write while the rf has not yet committed it.
  always_comb begin
    reg_d1 = rf_d1;
    reg_d2 = rf_d2;
    if (write_e_q && (rd_q == reg_s1) && (reg_s1 != 5'd0)) begin
      reg_d1 = write_d_q;
    end else begin
      reg_d1 = rf_d1;
    end
    if (write_e_q && (rd_q == reg_s2) && (reg_s2 != 5'd0)) begin
      reg_d2 = write_d_q;
    end else begin
      reg_d2 = rf_d2;
    end
  end
`else
  assign reg_d1 = rf_d1;
  assign reg_d2 = rf_d2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter (NUM_REQ=2). A second instance with
// CNT_W=2 shares all inputs so that counter saturation is observable.
module tb_rf_wb_arbiter;

  localparam int N = 2;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready, sat_ready;
  logic [N*5-1:0]  req_rd;
  logic [N*32-1:0] req_data;
  logic            wb_stall;
  logic            write_e, sat_we;
  logic [4:0]      rd, sat_rd;
  logic [31:0]     write_d, sat_wd;
  logic [4:0]      reg_s1, reg_s2;
  logic [31:0]     rf_d1, rf_d2, reg_d1, reg_d2, sat_d1, sat_d2;
  logic [15:0]     conflict_cnt;
  logic [1:0]      sat_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int          m_last;
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  int          m_cnt, m_cnt2;
  logic [31:0] rf_mem [32];

  // Captured expectations and observations of the last step
  logic [N-1:0] exp_ready, obs_ready;
  logic [31:0]  exp_d1, exp_d2, obs_d1, obs_d2;
  logic         obs_we;
  logic [4:0]   obs_rd;
  logic [31:0]  obs_wd;
  logic [15:0]  obs_cnt;
  logic [1:0]   obs_cnt2;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_REQ(N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .wb_stall(wb_stall),
    .write_e(write_e), .rd(rd), .write_d(write_d),
    .reg_s1(reg_s1), .reg_s2(reg_s2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .reg_d1(reg_d1), .reg_d2(reg_d2), .conflict_cnt(conflict_cnt)
  );

  rf_wb_arbiter #(.NUM_REQ(N), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(sat_ready),
    .req_rd(req_rd), .req_data(req_data), .wb_stall(wb_stall),
    .write_e(sat_we), .rd(sat_rd), .write_d(sat_wd),
    .reg_s1(reg_s1), .reg_s2(reg_s2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .reg_d1(sat_d1), .reg_d2(sat_d2), .conflict_cnt(sat_cnt)
  );

  // Winner = valid requester at the smallest cyclic distance after last.
  function automatic int model_grant(logic [N-1:0] v, int last);
    int best  = -1;
    int bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        int d;
        d = ((i - last - 1) % N + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [4:0] r, input logic [31:0] d);
    req_valid[i]       = v;
    req_rd[i*5 +: 5]   = r;
    req_data[i*32 +: 32] = d;
  endtask

  // One clock cycle: drive rf read data, capture combinational outputs,
  // advance the model across the edge, capture registered outputs.
  task automatic step();
    int g;
    bit cont;
    rf_d1 = rf_mem[reg_s1];
    rf_d2 = rf_mem[reg_s2];
    #2;
    g = (rst || wb_stall) ? -1 : model_grant(req_valid, m_last);
    exp_ready = (g < 0) ? '0 : (N'(1) << g);
    exp_d1 = (BYP && m_we && m_rd == reg_s1 && reg_s1 != 5'd0) ? m_wd : rf_d1;
    exp_d2 = (BYP && m_we && m_rd == reg_s2 && reg_s2 != 5'd0) ? m_wd : rf_d2;
    obs_ready = req_ready;
    obs_d1 = reg_d1;
    obs_d2 = reg_d2;
    cont = !wb_stall && ($countones(req_valid) >= 2);
    @(posedge clk);
    if (m_we) rf_mem[m_rd] = m_wd;
    if (rst) begin
      m_last = N - 1; m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (cont) begin
        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
        m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
      end
      if (g >= 0) begin
        m_last = g;
        m_rd   = req_rd[g*5 +: 5];
        m_wd   = req_data[g*32 +: 32];
        m_we   = (m_rd != 5'd0);
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
    obs_we = write_e; obs_rd = rd; obs_wd = write_d;
    obs_cnt = conflict_cnt; obs_cnt2 = sat_cnt;
  endtask

  task automatic test_reset();
    rst = 1'b1; wb_stall = 1'b0; reg_s1 = 5'd0; reg_s2 = 5'd0;
    set_req(0, 1'b1, 5'd1, 32'h11); set_req(1, 1'b1, 5'd2, 32'h22);
    step();
    checks++; if (obs_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", obs_ready); end
    checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", obs_we); end
    checks++; if (obs_rd !== 5'd0 || obs_wd !== 32'd0) begin failures++; $display("FAIL reset_port got rd=%0d wd=%h exp 0/0", obs_rd, obs_wd); end
    checks++; if (obs_cnt !== 16'd0 || obs_cnt2 !== 2'd0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", obs_cnt, obs_cnt2); end
    rst = 1'b0; set_req(0, 1'b0, 5'd0, 32'd0); set_req(1, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd4, 32'd42);
    step();
    checks++; if (obs_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", obs_ready); end
    checks++; if (obs_we !== 1'b1 || obs_rd !== 5'd4 || obs_wd !== 32'd42) begin failures++; $display("FAIL single_write got we=%b rd=%0d wd=%0d exp 1/4/42", obs_we, obs_rd, obs_wd); end
    set_req(0, 1'b0, 5'd0, 32'd0);
    step();
    checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL single_we_drop got=%b exp=0", obs_we); end
    reg_s1 = 5'd4; reg_s2 = 5'd0;
    step();
    checks++; if (obs_d1 !== 32'd42 || obs_d2 !== 32'd0) begin failures++; $display("FAIL single_read got d1=%0d d2=%0d exp 42/0", obs_d1, obs_d2); end
  endtask

  task automatic test_alternate();
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1'b1, 5'd2, 32'd99); set_req(1, 1'b1, 5'd3, 32'd7);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (obs_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10) || obs_ready !== exp_ready) begin failures++; $display("FAIL alt_ready[%0d] got=%b exp=%b", k, obs_ready, exp_ready); end
      checks++; if (obs_we !== 1'b1 || obs_rd !== ((k % 2 == 0) ? 5'd2 : 5'd3) || obs_wd !== ((k % 2 == 0) ? 32'd99 : 32'd7)) begin failures++; $display("FAIL alt_write[%0d] got rd=%0d wd=%0d", k, obs_rd, obs_wd); end
    end
    checks++; if (obs_cnt !== 16'd4) begin failures++; $display("FAIL alt_cnt got=%0d exp=4", obs_cnt); end
    checks++; if (obs_cnt2 !== 2'd3) begin failures++; $display("FAIL alt_cnt_sat got=%0d exp=3", obs_cnt2); end
  endtask

  task automatic test_x0();
    set_req(0, 1'b0, 5'd0, 32'd0); set_req(1, 1'b1, 5'd0, 32'hDEAD);
    step();
    checks++; if (obs_ready !== 2'b10) begin failures++; $display("FAIL x0_ready got=%b exp=10", obs_ready); end
    checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL x0_we got=%b exp=0", obs_we); end
    reg_s1 = 5'd0;
    set_req(0, 1'b1, 5'd2, 32'd99); set_req(1, 1'b1, 5'd3, 32'd7);
    step();
    checks++; if (obs_ready !== 2'b01) begin failures++; $display("FAIL x0_next_ready got=%b exp=01", obs_ready); end
    checks++; if (obs_d1 !== 32'd0) begin failures++; $display("FAIL x0_read got=%h exp=0", obs_d1); end
  endtask

  task automatic test_stall();
    logic [15:0] cnt_before;
    cnt_before = obs_cnt;
    wb_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (obs_ready !== 2'b00 || obs_we !== 1'b0) begin failures++; $display("FAIL stall[%0d] got ready=%b we=%b exp 00/0", k, obs_ready, obs_we); end
      checks++; if (obs_cnt !== cnt_before) begin failures++; $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", k, obs_cnt, cnt_before); end
    end
    wb_stall = 1'b0;
    step();
    checks++; if (obs_ready !== 2'b10) begin failures++; $display("FAIL stall_release got=%b exp=10", obs_ready); end
  endtask

  task automatic test_bypass();
    logic [31:0] want;
    rf_mem[5] = 32'h0BAD_0005;
    set_req(0, 1'b1, 5'd5, 32'h1234); set_req(1, 1'b0, 5'd0, 32'd0);
    step();
    set_req(0, 1'b0, 5'd0, 32'd0);
    reg_s1 = 5'd5; reg_s2 = 5'd5;
    step();
    want = BYP ? 32'h1234 : 32'h0BAD_0005;
    checks++; if (obs_d1 !== want) begin failures++; $display("FAIL bypass_d1 got=%h exp=%h", obs_d1, want); end
    checks++; if (obs_d2 !== want) begin failures++; $display("FAIL bypass_d2 got=%h exp=%h", obs_d2, want); end
  endtask

  task automatic test_sat_reset();
    rst = 1'b1; step(); rst = 1'b0;
    set_req(0, 1'b1, 5'd6, 32'h66); set_req(1, 1'b1, 5'd7, 32'h77);
    for (int k = 0; k < 5; k++) step();
    checks++; if (obs_cnt2 !== 2'd3 || obs_cnt !== 16'd5) begin failures++; $display("FAIL sat_cnt got=%0d/%0d exp=3/5", obs_cnt2, obs_cnt); end
    checks++; if (obs_we !== 1'b1) begin failures++; $display("FAIL sat_pending_we got=%b exp=1", obs_we); end
    rst = 1'b1;
    step();
    checks++; if (obs_ready !== 2'b00 || obs_we !== 1'b0) begin failures++; $display("FAIL mid_reset got ready=%b we=%b exp 00/0", obs_ready, obs_we); end
    checks++; if (obs_cnt !== 16'd0 || obs_cnt2 !== 2'd0) begin failures++; $display("FAIL mid_reset_cnt got=%0d/%0d exp=0/0", obs_cnt, obs_cnt2); end
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      wb_stall = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < N; i++) begin
        set_req(i, $urandom_range(0, 2) != 0,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)), $urandom);
      end
      reg_s1 = $urandom_range(0, 1) ? m_rd : 5'($urandom_range(0, 31));
      reg_s2 = $urandom_range(0, 1) ? m_rd : 5'($urandom_range(0, 31));
      step();
      checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", k, obs_ready, exp_ready); end
      checks++; if (obs_d1 !== exp_d1 || obs_d2 !== exp_d2) begin failures++; $display("FAIL rnd_read[%0d] got=%h/%h exp=%h/%h", k, obs_d1, obs_d2, exp_d1, exp_d2); end
      checks++; if (obs_we !== m_we || obs_rd !== m_rd || obs_wd !== m_wd) begin failures++; $display("FAIL rnd_port[%0d] got %b/%0d/%h exp %b/%0d/%h", k, obs_we, obs_rd, obs_wd, m_we, m_rd, m_wd); end
      checks++; if (obs_cnt !== 16'(m_cnt) || obs_cnt2 !== 2'(m_cnt2)) begin failures++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", k, obs_cnt, obs_cnt2, m_cnt, m_cnt2); end
    end
    rst = 1'b0; wb_stall = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : $urandom;
    m_last = N - 1; m_we = 1'b0; m_rd = 5'd0; m_wd = 32'd0; m_cnt = 0; m_cnt2 = 0;
    rst = 1'b1; wb_stall = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
    reg_s1 = 5'd0; reg_s2 = 5'd0; rf_d1 = 32'd0; rf_d2 = 32'd0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_alternate();
    test_x0();
    test_stall();
    test_bypass();
    test_sat_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
